key_schedule_rev256: RTL

KEY_SCHEDULE_REV256 -- requirements
Module: key_schedule_rev256

---
 rtl/key_schedule_rev256_pkg.sv | 27 ++
 rtl/key_schedule_rev256_sbox.sv | 29 ++
 rtl/key_schedule_rev256.sv | 126 ++++++++++++
 3 files changed

// File: rtl/key_schedule_rev256_pkg.sv
// Shared AES constants for the reverse AES-256 key schedule:
// FSM state encoding, round count and the Rcon table.
package key_schedule_rev256_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Highest round index of AES-256 (rk14 is the first key emitted).
    localparam logic [3:0] ROUNDS = 4'd14;

    // Rcon top byte for index 1..7; index 0 is never used and returns zero.
    function automatic logic [7:0] rcon(input logic [2:0] idx);
        case (idx)
            3'd1:    rcon = 8'h01;
            3'd2:    rcon = 8'h02;
            3'd3:    rcon = 8'h04;
            3'd4:    rcon = 8'h08;
            3'd5:    rcon = 8'h10;
            3'd6:    rcon = 8'h20;
            3'd7:    rcon = 8'h40;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_schedule_rev256_sbox.sv
// AES forward S-box, one byte, pure combinational lookup.
module key_schedule_rev256_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    // Row r holds S(16r) .. S(16r+15); element 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/key_schedule_rev256.sv
// Reverse AES-256 key schedule: loads the last eight schedule words
// (w52..w59) and walks the expansion backwards, emitting rk14 .. rk0
// over a valid/ready port.
// Optional build macro KEY_SCHEDULE_REV_ORIG_KEY_EN adds key_orig /
// key_orig_valid, which capture the recovered original key w0..w7.
//
// Handshake: round_key/rk_index are meaningful while rk_valid is high and
// stay frozen until rk_ready is seen; a transfer happens on a rising edge
// with rk_valid & rk_ready, and the next key appears the following cycle.
module key_schedule_rev256
    import key_schedule_rev256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   rk_index,
`ifdef KEY_SCHEDULE_REV_ORIG_KEY_EN
    output logic [255:0] key_orig,
    output logic         key_orig_valid,
`endif
    output logic         done
);

    state_t         state;
    state_t         state_nx;
    logic [255:0]   w_q;      // window w[j..j+7], w[j] in the top word
    logic [3:0]     idx_q;    // (j+4)/4
    logic           done_q;
    logic           xfer;
    logic           last;

    logic [31:0]    a0, a1, a2, a3, a4, a5, a6, a7;
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;
    logic [31:0]    w_m4;
    logic [255:0]   w_nx;

    assign a0 = w_q[255:224];
    assign a1 = w_q[223:192];
    assign a2 = w_q[191:160];
    assign a3 = w_q[159:128];
    assign a4 = w_q[127:96];
    assign a5 = w_q[95:64];
    assign a6 = w_q[63:32];
    assign a7 = w_q[31:0];

    assign xfer = (state == RUN) && rk_ready;
    assign last = xfer && (idx_q == 4'd0);

    // An even round index means (j+4) mod 8 = 0: RotWord + Rcon step.
    assign sub_in = idx_q[0] ? a3 : {a3[23:0], a3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        key_schedule_rev256_sbox u_sbox (
            .a (sub_in[8*g +: 8]),
            .y (sub_out[8*g +: 8])
        );
    end

    assign w_m4 = a4 ^ sub_out ^ (idx_q[0] ? 32'h0 : {rcon(idx_q[3:1]), 24'h0});

    // New window w[j-4..j+3]: four freshly recovered words above the old low half.
    assign w_nx = {w_m4, a5 ^ a4, a6 ^ a5, a7 ^ a6, a0, a1, a2, a3};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: start only matters in IDLE; rk0 transfer ends the run.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Window, round index and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q    <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if ((state == IDLE) && start) begin
                w_q   <= key_in;
                idx_q <= ROUNDS;
            end else if (xfer && (idx_q != 4'd0)) begin
                w_q   <= w_nx;
                idx_q <= idx_q - 4'd1;
            end
        end
    end

    // Output decode.
    always_comb begin
        busy      = (state == RUN);
        rk_valid  = (state == RUN);
        round_key = w_q[127:0];
        rk_index  = idx_q;
        done      = done_q;
    end

`ifdef KEY_SCHEDULE_REV_ORIG_KEY_EN
    // At the rk1 transfer the window is exactly w0..w7, the original key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_orig       <= '0;
            key_orig_valid <= 1'b0;
        end else begin
            key_orig_valid <= last;
            if (xfer && (idx_q == 4'd1)) key_orig <= w_q;
        end
    end
`endif

endmodule
